// File: rtl/booth_mult_arbiter_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
package booth_mult_arbiter_pkg;

    localparam int unsigned OPW          = 32;
    localparam int unsigned PRODW        = 64;
    localparam int unsigned MULT_LAT_DEF = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] x;
        logic [OPW-1:0] y;
    } operands_t;

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last, wrapping.
module booth_mult_arbiter_rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic [IDW-1:0] w_cand;
    logic           w_hit;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_hit   = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((32'(i_last) + k) % NREQ);
            if (!w_hit && i_req[w_cand]) begin
                w_hit = 1'b1;
                o_idx = w_cand;
            end
        end
        if (i_en && w_hit) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential Booth multiplier between NREQ requesters:
// round-robin grant, clear/run sequencing and a tagged response channel.
module booth_mult_arbiter
    import booth_mult_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned MULT_LAT = MULT_LAT_DEF,
    localparam int unsigned IDW      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_x,
    input  logic [NREQ*OPW-1:0] req_y,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [PRODW-1:0]    resp_data,
    output logic                busy,
    output logic                mult_reset,
    output logic [OPW-1:0]      mult_x,
    output logic [OPW-1:0]      mult_y,
    input  logic [PRODW-1:0]    mult_out
);

    localparam int unsigned CNTW = $clog2(MULT_LAT + 1);

    state_t          r_state;
    logic [IDW-1:0]  r_last_grant;
    logic [CNTW-1:0] r_cnt;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_arb_en;
    operands_t       w_ops [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_ops[g].x = req_x[g*OPW +: OPW];
        assign w_ops[g].y = req_y[g*OPW +: OPW];
    end

    // Grants are only offered while idle and out of reset.
    assign w_arb_en  = (r_state == ST_IDLE) && reset;
    assign req_ready = w_grant;

    booth_mult_arbiter_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .i_en   (w_arb_en),
        .o_grant(w_grant),
        .o_idx  (w_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_cnt        <= '0;
            mult_x       <= '0;
            mult_y       <= '0;
            mult_reset   <= 1'b1;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_data    <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        mult_x       <= w_ops[w_idx].x;
                        mult_y       <= w_ops[w_idx].y;
                        resp_id      <= w_idx;
                        r_last_grant <= w_idx;
                        busy         <= 1'b1;
                        r_state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_cnt      <= '0;
                    mult_reset <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    // Product is valid on the last run cycle; capture and re-clear.
                    if (r_cnt == CNTW'(MULT_LAT - 1)) begin
                        resp_data  <= mult_out;
                        resp_valid <= 1'b1;
                        mult_reset <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal products, then randomized traffic.
module tb_booth_mult_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 17;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ*32-1:0] req_y;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [63:0]       resp_data;
    logic              busy;
    logic              mult_reset;
    logic [31:0]       mult_x;
    logic [31:0]       mult_y;
    logic [63:0]       mult_out;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          acc_log[$];
    int          id_log[$];
    int          lat_log[$];
    logic [63:0] data_log[$];

    bit          m_busy = 1'b0;
    int          m_acc = 0;
    int          m_last = NREQ - 1;
    int          m_id = 0;
    logic [31:0] m_x = '0;
    logic [31:0] m_y = '0;
    logic [63:0] m_prod = '0;
    int          mcnt = 0;

    always #5 clk = ~clk;

    booth_mult_arbiter #(
        .NREQ    (NREQ),
        .MULT_LAT(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .busy      (busy),
        .mult_reset(mult_reset),
        .mult_x    (mult_x),
        .mult_y    (mult_y),
        .mult_out  (mult_out)
    );

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Stand-in multiplier: garbage until LAT-1 cycles after clear is released.
    always @(posedge clk) begin
        if (mult_reset) begin
            mcnt     <= 0;
            mult_out <= 64'hDEAD_BEEF_0BAD_F00D;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == LAT - 2) mult_out <= prod(mult_x, mult_y);
        end
    end

    // Reference model: one op in flight; p counts negedges since the accept sample.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        int g;
        int p;
        int j;
        cyc++;
        if (!reset) begin
            m_busy = 1'b0;
            m_last = NREQ - 1;
            m_x    = '0;
            m_y    = '0;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_id", 64'(resp_id), 64'd0);
            chk("rst_resp_data", resp_data, 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_mult_reset", 64'(mult_reset), 64'd1);
            chk("rst_mult_x", 64'(mult_x), 64'd0);
            chk("rst_mult_y", 64'(mult_y), 64'd0);
        end else begin
            p = cyc - m_acc;
            exp_ready = '0;
            g = -1;
            if (!m_busy) begin
                for (int i = 1; i <= NREQ; i++) begin
                    j = (m_last + i) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("mult_reset", 64'(mult_reset), 64'(!(m_busy && p >= 2 && p <= LAT + 1)));
            chk("resp_valid", 64'(resp_valid), 64'(m_busy && p >= LAT + 2));
            chk("mult_x", 64'(mult_x), 64'(m_x));
            chk("mult_y", 64'(mult_y), 64'(m_y));
            if (m_busy && p >= LAT + 2) begin
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_data", resp_data, m_prod);
            end
            if (m_busy && p >= LAT + 2 && resp_ready) begin
                data_log.push_back(resp_data);
                id_log.push_back(int'(resp_id));
                lat_log.push_back(p);
                m_busy = 1'b0;
            end else if (g >= 0) begin
                m_x    = req_x[g*32 +: 32];
                m_y    = req_y[g*32 +: 32];
                m_prod = prod(m_x, m_y);
                m_id   = g;
                m_last = g;
                m_acc  = cyc;
                m_busy = 1'b1;
                acc_log.push_back(g);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (acc_log.size() >= n) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_acc: accepts %0d expected %0d", acc_log.size(), n);
    endtask

    task automatic wait_resp(input int n);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (data_log.size() >= n) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_resp: responses %0d expected %0d", data_log.size(), n);
    endtask

    task automatic do_op(input int i, input logic [31:0] x, input logic [31:0] y);
        int na;
        int nr;
        na = acc_log.size();
        nr = data_log.size();
        req_x[i*32 +: 32] = x;
        req_y[i*32 +: 32] = y;
        req_valid = '0;
        req_valid[i] = 1'b1;
        wait_acc(na + 1);
        req_valid = '0;
        wait_resp(nr + 1);
    endtask

    initial begin
        int a;
        int b;
        bit seen;
        logic [63:0] exp4 [4];
        exp4[0] = 64'hFFFFFFFF_F7747564;
        exp4[1] = 64'h193DE4CE_D7437964;
        exp4[2] = 64'h00000000_00010609;
        exp4[3] = 64'h215D8B0A_7A419A1D;

        reset = 1'b1;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        resp_ready = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Single request; lat_log 19 = resp_valid seen 18 edges after the accept edge.
        b = data_log.size();
        do_op(0, 32'h00087234, 32'h00000348);
        chk("t1_data", data_log[b], 64'h1BB6BAA0);
        chk("t1_id", 64'(id_log[b]), 64'd0);
        chk("t1_lat", 64'(lat_log[b]), 64'd19);

        // All four valid straight out of reset.
        reset = 1'b0;
        req_x = {32'hB887CAAF, 32'hFFFFFEFD, 32'h50647236, 32'h00087234};
        req_y = {32'h887CAAF3, 32'hFFFFFEFD, 32'h50612336, 32'hFFFFFEFD};
        req_valid = '1;
        tick();
        reset = 1'b1;
        a = acc_log.size();
        b = data_log.size();
        for (int k = 0; k < 4; k++) begin
            wait_acc(a + k + 1);
            req_valid[acc_log[acc_log.size()-1]] = 1'b0;
        end
        wait_resp(b + 4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_grant", 64'(acc_log[a+k]), 64'(k));
            chk("t2_data", data_log[b+k], exp4[k]);
            chk("t2_id", 64'(id_log[b+k]), 64'(k));
        end

        // Fairness between requesters 0 and 2.
        a = acc_log.size();
        b = data_log.size();
        req_x[0 +: 32] = $urandom;
        req_y[0 +: 32] = $urandom;
        req_x[64 +: 32] = $urandom;
        req_y[64 +: 32] = $urandom;
        req_valid = 4'b0101;
        wait_acc(a + 4);
        req_valid = '0;
        wait_resp(b + 4);
        for (int k = 0; k < 4; k++) chk("t3_grant", 64'(acc_log[a+k]), 64'((k % 2) * 2));

        // Backpressure in DONE with everyone else requesting.
        a = acc_log.size();
        b = data_log.size();
        resp_ready = 1'b0;
        req_x[32 +: 32] = 32'h50647236;
        req_y[32 +: 32] = 32'h50612336;
        req_valid = 4'b0010;
        wait_acc(a + 1);
        req_valid = '1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = resp_valid;
        end
        chk("t4_resp_seen", 64'(seen), 64'd1);
        repeat (10) tick();
        resp_ready = 1'b1;
        wait_acc(a + 2);
        req_valid = '0;
        wait_resp(b + 2);
        chk("t4_grant0", 64'(acc_log[a]), 64'd1);
        chk("t4_grant1", 64'(acc_log[a+1]), 64'd2);
        chk("t4_data", data_log[b], 64'h193DE4CE_D7437964);

        // Reset mid-run drops the op and restarts the pointer at requester 0.
        a = acc_log.size();
        b = data_log.size();
        req_x[64 +: 32] = 32'h12345678;
        req_y[64 +: 32] = 32'h9ABCDEF0;
        req_valid = 4'b0100;
        wait_acc(a + 1);
        req_valid = '0;
        repeat (8) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (25) tick();
        chk("t5_no_resp", 64'(data_log.size()), 64'(b));
        req_x[32 +: 32] = 32'h00000001;
        req_y[32 +: 32] = 32'h50647236;
        req_valid = 4'b1010;
        wait_acc(a + 2);
        req_valid = '0;
        wait_resp(b + 1);
        chk("t5_grant", 64'(acc_log[a+1]), 64'd1);
        chk("t5_data", data_log[b], 64'h50647236);
        chk("t5_id", 64'(id_log[b]), 64'd1);

        // Boundary operands.
        b = data_log.size();
        do_op(3, 32'hB887CAAF, 32'h00000000);
        do_op(3, 32'hB887CAAF, 32'h00000001);
        do_op(2, 32'h00000000, 32'h50647236);
        chk("t6_zero_y", data_log[b], 64'd0);
        chk("t6_one_y", data_log[b+1], 64'hFFFFFFFF_B887CAAF);
        chk("t6_zero_x", data_log[b+2], 64'd0);
        chk("t6_id", 64'(id_log[b+2]), 64'd2);

        // Random traffic: operands churn every cycle, random backpressure.
        b = data_log.size();
        for (int t = 0; t < 800; t++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_x[i*32 +: 32] = $urandom;
                req_y[i*32 +: 32] = $urandom;
            end
            resp_ready = ($urandom_range(3) != 0);
            tick();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (30) tick();
        chk("rand_progress", 64'(data_log.size() > b + 10), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one sequential radix-4 Booth multiplier (32x32 signed -> 64) between NREQ requesters.
- Round-robin grant, valid/ready request handshake per requester, single response channel tagged with the requester ID.
- Sequences the multiplier: clear pulse, fixed-length run, result capture.
- Sits between the multiplier instance and its client blocks.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MULT_LAT, 17, cycles the multiplier needs after its clear pulse before its output is valid.
- IDW, $clog2(NREQ), width of the requester ID (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_x  in  NREQ*32  packed multiplicands; requester i uses bits [32i+31:32i].
- req_y  in  NREQ*32  packed multipliers, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index of the result.
- resp_data  out  64  signed product.
- busy  out  1  high in any state other than IDLE.
- mult_reset  out  1  active-high clear to the multiplier.
- mult_x  out  32  operand x to the multiplier.
- mult_y  out  32  operand y to the multiplier.
- mult_out  in  64  multiplier product.

Behaviour:
- FSM states: IDLE, CLEAR, RUN, DONE.
- Reset (reset=0, async):
  - state=IDLE, last_grant=NREQ-1, cnt=0.
  - mult_x=mult_y=0, mult_reset=1.
  - resp_valid=0, resp_id=0, resp_data=0, busy=0, req_ready=0.
- IDLE:
  - mult_reset=1.
  - If any req_valid: grant g = first valid index searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g]=1, combinational, only in IDLE; all other ready bits 0.
  - On that edge: latch req_x[g]/req_y[g] into mult_x/mult_y, latch g into resp_id, last_grant<=g, go to CLEAR.
  - No valid: stay IDLE, last_grant unchanged.
- CLEAR: exactly one cycle, mult_reset=1, operands stable; go to RUN with cnt=0.
- RUN:
  - mult_reset=0; cnt increments each cycle.
  - At the edge where cnt==MULT_LAT-1: resp_data<=mult_out, resp_valid<=1, go to DONE.
- DONE:
  - mult_reset=1; resp_valid, resp_id and resp_data held stable.
  - On resp_valid&&resp_ready: resp_valid<=0, go to IDLE.
  - No new grant while in DONE (backpressure stalls all requesters).
- Latency: resp_valid rises MULT_LAT+1 cycles after the accept edge. Minimum request-to-request spacing is MULT_LAT+3 cycles.
- mult_x/mult_y change only on an accept edge; they are constant from CLEAR through DONE.
- req_valid dropping before grant: no effect, request simply not seen. req_valid dropping after accept: in-flight operation unaffected.
- Requesters are not required to hold operands after the accept edge.
- Reset mid-operation (any state): in-flight product discarded, no response issued, arbitration pointer restarts at requester 0.
- Products are full-width two's complement; no truncation or saturation.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, CLEAR=1, RUN=2, DONE=3).
  - Operand width 32 and product width 64.
  - Default MULT_LAT=17.
- Sub-module rr_arbiter (NREQ): inputs req vector, last_grant, enable; outputs one-hot grant and encoded index. Purely combinational; the pointer register stays in the parent.
- Multiplier instantiated at the parent level, not inside this block.

Test Plan:
- Single request, bench wires in the Booth multiplier: req0 x=0x00087234 y=0x00000348 -> resp_data=0x1BB6BAA0, resp_id=0, resp_valid exactly 18 cycles after accept.
- All four requests valid from reset, resp_ready=1, with:
  - req0 x=0x87234, y=0xFFFFFEFD
  - req1 x=0x50647236, y=0x50612336
  - req2 x=0xFFFFFEFD, y=0xFFFFFEFD
  - req3 x=0xB887CAAF, y=0x887CAAF3

  -> grants in order 0,1,2,3; results 0xFFFFFFFFF7747564, 0x193DE4CED7437964, 0x10609, 0x215D8B0A7A419A1D, each with the matching resp_id.
- Fairness: req0 and req2 held valid continuously -> grant sequence 0,2,0,2; req_ready never high for 1 or 3.
- Backpressure: resp_ready low for 10 cycles in DONE -> resp_valid/resp_data/resp_id stable, req_ready all 0, mult_x unchanged; on release, IDLE next cycle, then next grant.
- Reset pulse for 2 cycles mid-RUN -> all outputs take reset values immediately, no response for the dropped op; then req1 x=0x1 y=0x50647236 -> resp_data=0x50647236, resp_id=1.
- Boundary operands: x=0xB887CAAF y=0x0 -> 0x0; x=0xB887CAAF y=0x1 -> 0xFFFFFFFFB887CAAF; x=0x0 y=0x50647236 -> 0x0.
